// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'd0;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'd0;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc_plus_one;
  } queueEntry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction FIFO; flush wins over push and pop.
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           push,
  input  queueEntry_t                    pushData,
  input  logic                           pop,
  input  logic                           flush,
  output queueEntry_t                    headData,
  output logic [$clog2(QUEUE_DEPTH):0]   count,
  output logic                           empty,
  output logic                           full
);

  localparam int unsigned PtrW = $clog2(QUEUE_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  queueEntry_t         entries [QUEUE_DEPTH];
  logic [PtrW-1:0]     headQ, tailQ;
  logic [CntW-1:0]     countQ;
  logic                doPush, doPop;

  assign empty    = (countQ == '0);
  assign full     = (countQ == CntW'(QUEUE_DEPTH));
  assign count    = countQ;
  assign headData = entries[headQ];

  // A push into a full queue is only accepted when the head leaves the same cycle.
  assign doPush = push && !flush && (!full || pop);
  assign doPop  = pop && !flush && !empty;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      headQ  <= '0;
      tailQ  <= '0;
      countQ <= '0;
    end else if (flush) begin
      headQ  <= '0;
      tailQ  <= '0;
      countQ <= '0;
    end else begin
      if (doPush) tailQ <= tailQ + PtrW'(1);
      if (doPop)  headQ <= headQ + PtrW'(1);
      unique case ({doPush, doPop})
        2'b10:   countQ <= countQ + CntW'(1);
        2'b01:   countQ <= countQ - CntW'(1);
        default: countQ <= countQ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (doPush) entries[tailQ] <= pushData;
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues imem reads under a queue credit and
// applies execute redirects by flushing wrong-path work.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = 2,
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] address_imem,
  input  logic [31:0] q_imem,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] decode_ir,
  output logic [31:0] decode_pc,
  output logic        decode_valid
);

  localparam int unsigned CountW = $clog2(QUEUE_DEPTH) + 1;
  localparam int unsigned CredW  = CountW + 1;

  logic [31:0]       pc_q, pcD;
  logic [31:0]       inflight_pc_q, inflightPcD;
  logic              inflight_q, inflightD;
  logic              kill_q, killD;

  logic [CountW-1:0] count;
  logic              empty, full;
  logic              pop, issue, capture;
  queueEntry_t       head, pushData;

  fetch_queue #(
    .QUEUE_DEPTH(QUEUE_DEPTH)
  ) u_queue (
    .clock   (clock),
    .reset   (reset),
    .push    (capture),
    .pushData(pushData),
    .pop     (pop),
    .flush   (redirect_valid),
    .headData(head),
    .count   (count),
    .empty   (empty),
    .full    (full)
  );

  always_comb begin
    pop      = !empty && !stall && !redirect_valid;
    // count + inflight - pop < depth, rearranged to avoid underflow
    issue    = !redirect_valid &&
               ((CredW'(count) + CredW'(inflight_q)) < (CredW'(QUEUE_DEPTH) + CredW'(pop)));
    capture  = inflight_q && !kill_q && !redirect_valid;
    pushData = '{ir: q_imem, pc_plus_one: inflight_pc_q + 32'd1};

    pcD         = pc_q;
    inflightD   = 1'b0;
    inflightPcD = inflight_pc_q;
    killD       = 1'b0;
    if (redirect_valid) begin
      pcD   = redirect_pc;
      killD = inflight_q;
    end else if (issue) begin
      pcD         = pc_q + 32'd1;
      inflightD   = 1'b1;
      inflightPcD = pc_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      inflight_pc_q <= RESET_PC;
      inflight_q    <= 1'b0;
      kill_q        <= 1'b0;
    end else begin
      pc_q          <= pcD;
      inflight_pc_q <= inflightPcD;
      inflight_q    <= inflightD;
      kill_q        <= killD;
    end
  end

  always_comb begin
    address_imem = pc_q;
    decode_valid = !empty;
    decode_ir    = empty ? NOP_INSTR : head.ir;
    decode_pc    = empty ? 32'd0 : head.pc_plus_one;
  end

  queueNoOverflow: assert property (@(posedge clock) disable iff (reset)
    !(capture && full && !pop));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; imem model returns address + 100.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address_imem;
  logic [31:0] q_imem;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        stall = 1'b0;
  logic [31:0] decode_ir;
  logic [31:0] decode_pc;
  logic        decode_valid;

  int checks = 0;
  int errors = 0;

  fetch_unit #(
    .QUEUE_DEPTH(2),
    .RESET_PC   (32'd0)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .address_imem  (address_imem),
    .q_imem        (q_imem),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .stall         (stall),
    .decode_ir     (decode_ir),
    .decode_pc     (decode_pc),
    .decode_valid  (decode_valid)
  );

  always #5 clock = ~clock;

  // Synchronous imem: imem[a] = a + 100 (mod 2^32)
  always_ff @(posedge clock) q_imem <= address_imem + 32'd100;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chkDecode(input string tag, input logic v, input logic [31:0] ir,
                           input logic [31:0] pc);
    chk({tag, ".valid"}, {31'd0, decode_valid}, {31'd0, v});
    chk({tag, ".ir"}, decode_ir, ir);
    chk({tag, ".pc"}, decode_pc, pc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #2;
    chk("rst.addr", address_imem, 32'd0);
    chkDecode("rst", 1'b0, 32'd0, 32'd0);
    step();
    step();
    reset = 1'b0;
    // cycle 0
    chk("c0.addr", address_imem, 32'd0);
    chkDecode("c0", 1'b0, 32'd0, 32'd0);
    step(); // c1
    chk("c1.addr", address_imem, 32'd1);
    chkDecode("c1", 1'b0, 32'd0, 32'd0);
    step(); // c2
    chk("c2.addr", address_imem, 32'd2);
    chkDecode("c2", 1'b1, 32'd100, 32'd1);
    step(); // c3: stall begins
    stall = 1'b1;
    chk("c3.addr", address_imem, 32'd3);
    chkDecode("c3", 1'b1, 32'd101, 32'd2);
    for (int c = 4; c <= 6; c++) begin
      step();
      chk($sformatf("c%0d.addr", c), address_imem, 32'd3);
      chkDecode($sformatf("c%0d", c), 1'b1, 32'd101, 32'd2);
    end
    step(); // c7: stall released, 101 finally consumed
    stall = 1'b0;
    chk("c7.addr", address_imem, 32'd3);
    chkDecode("c7", 1'b1, 32'd101, 32'd2);
    step(); // c8
    chk("c8.addr", address_imem, 32'd4);
    chkDecode("c8", 1'b1, 32'd102, 32'd3);
    step(); // c9
    chk("c9.addr", address_imem, 32'd5);
    chkDecode("c9", 1'b1, 32'd103, 32'd4);
    step(); // c10: redirect to 40
    redirect_valid = 1'b1;
    redirect_pc    = 32'd40;
    chkDecode("c10", 1'b1, 32'd104, 32'd5);
    step(); // c11
    redirect_valid = 1'b0;
    chk("c11.addr", address_imem, 32'd40);
    chkDecode("c11", 1'b0, 32'd0, 32'd0);
    step(); // c12
    chk("c12.addr", address_imem, 32'd41);
    chkDecode("c12", 1'b0, 32'd0, 32'd0);
    step(); // c13
    chkDecode("c13", 1'b1, 32'd140, 32'd41);
    step(); // c14: stall to fill queue
    stall = 1'b1;
    chkDecode("c14", 1'b1, 32'd141, 32'd42);
    step(); // c15: queue full, redirect under stall
    redirect_valid = 1'b1;
    redirect_pc    = 32'd60;
    chkDecode("c15", 1'b1, 32'd141, 32'd42);
    step(); // c16
    redirect_valid = 1'b0;
    chk("c16.addr", address_imem, 32'd60);
    chkDecode("c16", 1'b0, 32'd0, 32'd0);
    step(); // c17
    chkDecode("c17", 1'b0, 32'd0, 32'd0);
    step(); // c18
    chkDecode("c18", 1'b1, 32'd160, 32'd61);
    step(); // c19
    stall = 1'b0;
    chkDecode("c19", 1'b1, 32'd160, 32'd61);
    step(); // c20: redirect to last word address
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    chkDecode("c20", 1'b1, 32'd161, 32'd62);
    step(); // c21
    redirect_valid = 1'b0;
    chk("c21.addr", address_imem, 32'hFFFF_FFFF);
    chkDecode("c21", 1'b0, 32'd0, 32'd0);
    step(); // c22
    chk("c22.addr", address_imem, 32'd0);
    step(); // c23
    chkDecode("c23", 1'b1, 32'd99, 32'd0);
    step(); // c24
    chkDecode("c24", 1'b1, 32'd100, 32'd1);
    // Asynchronous reset between edges
    #3;
    reset = 1'b1;
    #1;
    chk("arst.addr", address_imem, 32'd0);
    chkDecode("arst", 1'b0, 32'd0, 32'd0);
    step();
    reset = 1'b0;
    // cycle 0 after second release
    chk("r0.addr", address_imem, 32'd0);
    chkDecode("r0", 1'b0, 32'd0, 32'd0);
    step();
    chkDecode("r1", 1'b0, 32'd0, 32'd0);
    step();
    chkDecode("r2", 1'b1, 32'd100, 32'd1);
    step();
    chkDecode("r3", 1'b1, 32'd101, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that sits directly upstream of the decode stage. It owns the program counter, issues word addresses to the synchronous instruction memory, and buffers returned instructions in a small queue. The queue lets decode stalls be absorbed without losing in-flight fetches. It also applies branch/jump redirects from execute by flushing all wrong-path instructions and restarting fetch at the target.

## Interface
- `QUEUE_DEPTH`, default 2: instruction queue entries; minimum 2, power of two.
- `RESET_PC`, default 32'd0: PC loaded on reset.

Ports:
- `clock`  in  1: single clock; all state updates on rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state immediately.
- `address_imem`  out  32: word address to imem; equals the PC register.
- `q_imem`  in  32: imem read data; valid the cycle after its address was presented.
- `redirect_valid`  in  1: execute resolved a taken branch/jump this cycle.
- `redirect_pc`  in  32: target word address, sampled when `redirect_valid`=1.
- `stall`  in  1: decode cannot accept this cycle; head is held.
- `decode_ir`  out  32: instruction at queue head; 32'd0 (nop) when queue empty.
- `decode_pc`  out  32: PC+1 of the head instruction; 32'd0 when queue empty.
- `decode_valid`  out  1: head holds a real instruction.

## Operation
- State:
  - `pc_q`: next address to fetch.
  - `inflight_q`: an imem read was issued last cycle.
  - `kill_q`: the in-flight read belongs to a flushed path.
  - Queue entries: {ir, pc_plus_one} with head/tail pointers and count.
- Pop: `decode_valid`=1 and `stall`=0 and `redirect_valid`=0.
- Issue, when `redirect_valid`=0: issue if (count + `inflight_q` − pop) < `QUEUE_DEPTH`.
  - On issue: `pc_q` <= `pc_q`+1 (mod 2^32 wrap); `inflight_q` <= 1; the issued PC is held in `inflight_pc_q`.
  - Without issue: `inflight_q` <= 0 and `address_imem` keeps its value (harmless re-read).
- Capture: if `inflight_q`=1 and `kill_q`=0, push {`q_imem`, `inflight_pc_q`+1}.
  - Push and pop in the same cycle are both legal; count is unchanged.
- Redirect (`redirect_valid`=1) has highest priority; at the next edge:
  - queue emptied;
  - `pc_q` <= `redirect_pc`;
  - `kill_q` <= `inflight_q`;
  - no issue, no push, no pop.
  - This applies regardless of `stall`.
- A killed response is discarded in its return cycle; `kill_q` then clears.
- The queue never overflows, by the issue credit rule; an attempted push into a full queue is an assertion failure.
- Empty queue: outputs are nop/0/0, and `stall` is ignored.

## Timing
- Reset values: `pc_q`=`RESET_PC`, queue empty, `inflight_q`=0, `kill_q`=0, `address_imem`=`RESET_PC`, `decode_ir`=0, `decode_pc`=0, `decode_valid`=0.
- Latency: address issued in cycle c → captured at the end of c+1 → visible to decode in cycle c+2.
  - First instruction after reset release appears in cycle 2.
- Throughput: 1 instruction/cycle sustained with `QUEUE_DEPTH`=2 and no stalls.
- Redirect in cycle r:
  - `decode_valid`=0 in r+1;
  - target address issued in r+1;
  - target instruction at decode in r+3, i.e. a 2-cycle bubble after the redirect cycle.
- Stall: head and outputs are held stable; fetch continues until the queue plus in-flight reach depth, then `address_imem` holds.
- Reset asserted mid-operation: all state clears asynchronously and outputs drop to reset values in the same cycle. Fetch restarts at `RESET_PC` on the first edge after deassertion.

## Structure
- Shared package holds:
  - `NOP_INSTR` = 32'd0;
  - `RESET_PC` default;
  - the queue entry struct {ir[31:0], pc_plus_one[31:0]}.
- Sub-module `fetch_queue`: circular FIFO with parameter `QUEUE_DEPTH`, push/pop/flush inputs, and count/empty/full outputs.
  - Flush has priority over push and pop.
- `fetch_unit` keeps the PC, issue credit, in-flight/kill tracking and redirect priority.

## Test plan
- Reset release, imem[i]=i+100, no stall:
  - `address_imem` reads 0,1,2,…;
  - `decode_ir`=100 in cycle 2, then 101, 102 on consecutive cycles;
  - `decode_pc`=1,2,3.
- `stall`=1 for 4 cycles from cycle 3:
  - `decode_ir` holds 101;
  - `address_imem` stops after 2 more issues;
  - after release, the sequence resumes 102,103 with no loss or duplication.
- `redirect_valid`=1, `redirect_pc`=32'd40 in cycle 5:
  - `decode_valid`=0 in cycles 6–7;
  - `decode_ir`=imem[40] with `decode_pc`=41 in cycle 8;
  - no instruction from the old path ever appears.
- Redirect while `stall`=1 and queue full: queue flushes, then the target instruction appears 3 cycles after the redirect cycle.
- PC wrap: redirect to 32'hFFFFFFFF gives `decode_pc`=0, then the next fetch address is 0.
- Reset asserted mid-stream between edges: outputs 0 immediately; after release, the first instruction is imem[0] in cycle 2.
